// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and defaults for the bus trace capture block
package trace_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int TS_W_DEF  = 32;
  // Timestamp field is sized for the widest supported counter; narrower
  // counters are zero-extended into it.
  localparam int TS_MAX    = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ARMED  = 2'b01,
    ST_POST   = 2'b10,
    ST_FROZEN = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    K_READ       = 2'b00,
    K_WRITE      = 2'b01,
    K_TRIG_READ  = 2'b10,
    K_TRIG_WRITE = 2'b11
  } kind_t;

  typedef struct packed {
    logic [31:0]       addr;
    logic [31:0]       data;
    kind_t             kind;
    logic [TS_MAX-1:0] ts;
  } entry_t;

  // bit0 marks a write, bit1 marks the access that fired the trigger
  function automatic kind_t make_kind(input logic is_write, input logic is_trig);
    return kind_t'({is_trig, is_write});
  endfunction

endpackage

// File: rtl/snapshot_fifo.sv
// rtl/snapshot_fifo.sv - first-word-fall-through FIFO of trace entries
module snapshot_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  entry_t                 entry_i,
  input  logic                   pop_i,
  output entry_t                 head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;

  logic            w_pop;
  logic            w_push;

  assign empty_o = (r_level == '0);
  assign full_o  = (r_level == (AW+1)'(DEPTH));
  assign level_o = r_level;
  // Head is visible combinationally; when empty it shows stale storage.
  assign head_o  = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= entry_i;
  end

endmodule

// File: rtl/bus_trace_capture.sv
// rtl/bus_trace_capture.sv - triggered core-bus access trace capture
module bus_trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TS_W  = TS_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm_i,
  input  logic [31:0]            trig_addr_i,
  input  logic [7:0]             post_count_i,
  input  logic [31:0]            address_i,
  input  logic [31:0]            data_read_i,
  input  logic [31:0]            data_write_i,
  input  logic [3:0]             data_w_i,
  input  logic                   data_access_i,
  input  logic                   stall_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            out_addr_o,
  output logic [31:0]            out_data_o,
  output logic [1:0]             out_kind_o,
  output logic [TS_W-1:0]        out_ts_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic [15:0]            drop_count_o,
  output logic [1:0]             state_o
);

  state_t          r_state;
  logic [7:0]      r_post_cnt;
  logic [TS_W-1:0] r_ts;
  logic            r_overflow;
  logic [15:0]     r_drop_cnt;

  logic            w_event;
  logic            w_capturing;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  logic            w_match;
  logic            w_is_write;
  logic            w_full;
  logic            w_empty;
  entry_t          w_entry;
  entry_t          w_head;

  assign w_event     = data_access_i && !stall_i;
  assign w_capturing = (r_state == ST_ARMED) || (r_state == ST_POST);
  assign w_push      = w_event && w_capturing;
  assign w_match     = (address_i == trig_addr_i);
  assign w_is_write  = (data_w_i != 4'd0);
  assign w_pop       = !w_empty && out_ready_i;
  assign w_drop      = w_push && w_full && !w_pop;

  // Only the access that fires the trigger from ARMED is flagged.
  assign w_entry.addr = address_i;
  assign w_entry.data = w_is_write ? data_write_i : data_read_i;
  assign w_entry.kind = make_kind(w_is_write, (r_state == ST_ARMED) && w_match);
  assign w_entry.ts   = TS_MAX'(r_ts);

  snapshot_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .entry_i (w_entry),
    .pop_i   (out_ready_i),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level_o)
  );

  assign out_valid_o  = !w_empty;
  assign out_addr_o   = w_head.addr;
  assign out_data_o   = w_head.data;
  assign out_kind_o   = w_head.kind;
  assign out_ts_o     = w_head.ts[TS_W-1:0];
  assign overflow_o   = r_overflow;
  assign drop_count_o = r_drop_cnt;
  assign state_o      = r_state;

  // Capture FSM: arm, wait for trigger, count post-trigger events, freeze.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_post_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_FROZEN: begin
          if (arm_i) r_state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (w_event && w_match) begin
            if (post_count_i == 8'd0) begin
              r_state <= ST_FROZEN;
            end else begin
              r_state    <= ST_POST;
              r_post_cnt <= post_count_i;
            end
          end
        end
        ST_POST: begin
          if (w_event) begin
            r_post_cnt <= r_post_cnt - 8'd1;
            if (r_post_cnt == 8'd1) r_state <= ST_FROZEN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Free-running timestamp, wraps at its natural width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 1'b1;
  end

  // Sticky overflow and saturating count of entries lost to a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 16'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bus_trace_capture.sv
// tb/tb_bus_trace_capture.sv - scoreboard bench for bus_trace_capture
module tb_bus_trace_capture;

  localparam int DEPTH = 8;
  localparam int TS_W  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm_i = 1'b0;
  logic [31:0] trig_addr_i = 32'hFFFF_FFF0;
  logic [7:0]  post_count_i = 8'd0;
  logic [31:0] address_i = '0;
  logic [31:0] data_read_i = '0;
  logic [31:0] data_write_i = '0;
  logic [3:0]  data_w_i = '0;
  logic        data_access_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic        out_valid_o;
  logic [31:0] out_addr_o;
  logic [31:0] out_data_o;
  logic [1:0]  out_kind_o;
  logic [TS_W-1:0] out_ts_o;
  logic [3:0]  level_o;
  logic        overflow_o;
  logic [15:0] drop_count_o;
  logic [1:0]  state_o;

  bus_trace_capture #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .reset(rst), .arm_i(arm_i), .trig_addr_i(trig_addr_i),
    .post_count_i(post_count_i), .address_i(address_i),
    .data_read_i(data_read_i), .data_write_i(data_write_i),
    .data_w_i(data_w_i), .data_access_i(data_access_i), .stall_i(stall_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_addr_o(out_addr_o), .out_data_o(out_data_o),
    .out_kind_o(out_kind_o), .out_ts_o(out_ts_o), .level_o(level_o),
    .overflow_o(overflow_o), .drop_count_o(drop_count_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  kind;
    logic [31:0] ts;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int pops = 0;
  logic [31:0] last_ts = '0;

  // reference model: phase 0 idle, 1 armed, 2 post-trigger, 3 frozen
  int          m_phase = 0;
  int          m_left  = 0;
  int          m_level = 0;
  int          m_drops = 0;
  bit          m_ovf   = 0;
  logic [31:0] m_ts    = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: check registered status, then apply this cycle's inputs
  always @(negedge clk) begin
    if (rst) begin
      m_phase = 0; m_left = 0; m_level = 0; m_drops = 0; m_ovf = 0; m_ts = '0;
      exp_q.delete();
      chk("rst_state", state_o, 0);
      chk("rst_level", level_o, 0);
      chk("rst_valid", out_valid_o, 0);
      chk("rst_ovf", overflow_o, 0);
      chk("rst_drops", drop_count_o, 0);
    end else begin
      bit   ev, pop, cap, trig;
      int   lvl0;
      exp_t e;
      chk("state", state_o, m_phase);
      chk("level", level_o, m_level);
      chk("valid", out_valid_o, m_level != 0);
      chk("overflow", overflow_o, m_ovf);
      chk("drops", drop_count_o, m_drops);
      ev   = data_access_i && !stall_i;
      lvl0 = m_level;
      pop  = (lvl0 > 0) && out_ready_i;
      cap  = 0;
      trig = 0;
      if (m_phase == 0 || m_phase == 3) begin
        if (arm_i) m_phase = 1;
      end else if (m_phase == 1) begin
        if (ev) begin
          cap = 1;
          if (address_i == trig_addr_i) begin
            trig = 1;
            if (post_count_i == 0) m_phase = 3;
            else begin m_phase = 2; m_left = post_count_i; end
          end
        end
      end else if (ev) begin
        cap = 1;
        m_left = m_left - 1;
        if (m_left == 0) m_phase = 3;
      end
      m_level = lvl0 - (pop ? 1 : 0);
      if (cap) begin
        if (lvl0 < DEPTH || pop) begin
          e.addr = address_i;
          e.data = (data_w_i != 0) ? data_write_i : data_read_i;
          e.kind = {trig, data_w_i != 0};
          e.ts   = m_ts;
          exp_q.push_back(e);
          m_level = m_level + 1;
        end else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops = m_drops + 1;
        end
      end
      m_ts = m_ts + 32'd1;
    end
  end

  // monitor: every accepted head is compared against the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_underflow: got an entry expected none at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_addr", out_addr_o, e.addr);
        chk("out_data", out_data_o, e.data);
        chk("out_kind", out_kind_o, e.kind);
        chk("out_ts", out_ts_o, e.ts);
      end
      pops++;
      last_ts = out_ts_o;
    end
  end

  task automatic cyc(input logic arm, input logic acc, input logic stl,
                     input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] rd, input logic rdy);
    arm_i = arm; data_access_i = acc; stall_i = stl; address_i = a;
    data_w_i = be; data_write_i = wd; data_read_i = rd; out_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(0, 0, 0, $urandom, 4'd0, $urandom, $urandom, rdy);
  endtask

  task automatic ev_rd(input logic [31:0] a, input logic [31:0] d, input logic rdy);
    cyc(0, 1, 0, a, 4'd0, $urandom, d, rdy);
  endtask

  task automatic ev_wr(input logic [31:0] a, input logic rdy);
    cyc(0, 1, 0, a, 4'($urandom_range(1, 15)), $urandom, $urandom, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(0);
    idle(0);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (out_valid_o && n < 40) begin
      idle(1);
      n++;
    end
    chk("drain_level", level_o, 0);
    chk("drain_sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    int p0;
    logic [31:0] addrs [4];

    do_reset();

    // three reads while armed, consumer always ready
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    p0 = pops;
    ev_rd(32'h100, 32'hA, 1);
    ev_rd(32'h104, 32'hB, 1);
    ev_rd(32'h108, 32'hC, 1);
    drain();
    chk("reads_popped", pops - p0, 3);

    // trigger on a write with two post-trigger events
    do_reset();
    trig_addr_i = 32'h200; post_count_i = 8'd2;
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    p0 = pops;
    ev_wr(32'h1FC, 1);
    ev_wr(32'h200, 1);
    ev_wr(32'h204, 1);
    ev_wr(32'h208, 1);
    ev_wr(32'h20C, 1);
    drain();
    chk("trig_popped", pops - p0, 4);
    chk("trig_frozen", state_o, 2'b11);

    // overflow, then push and pop together on a full FIFO
    do_reset();
    trig_addr_i = 32'hFFFF_FFF0; post_count_i = 8'd0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) ev_rd(32'h1000 + 32'(i * 4), $urandom, 0);
    chk("ovf_level", level_o, 8);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_drops", drop_count_o, 2);
    ev_wr(32'h2000, 1);
    chk("full_pp_level", level_o, 8);
    chk("full_pp_drops", drop_count_o, 2);
    drain();

    // stalled access only counts when it completes
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    p0 = pops;
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 32'h300, 4'd0, 0, 32'h55, 1);
    cyc(0, 1, 0, 32'h300, 4'd0, 0, 32'h55, 1);
    drain();
    chk("stall_popped", pops - p0, 1);
    chk("stall_ts", last_ts, 4);

    // reset while collecting post-trigger events with five entries held
    do_reset();
    trig_addr_i = 32'h400; post_count_i = 8'd20;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    ev_rd(32'h400, $urandom, 0);
    for (int i = 0; i < 4; i++) ev_wr(32'h404 + 32'(i * 4), 0);
    chk("post_level", level_o, 5);
    chk("post_state", state_o, 2'b10);
    rst = 1'b1;
    #1;
    chk("async_valid", out_valid_o, 0);
    chk("async_state", state_o, 0);
    chk("async_drops", drop_count_o, 0);
    chk("async_level", level_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    trig_addr_i = 32'hFFFF_FFF0;
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    p0 = pops;
    ev_rd(32'h500, 32'h1, 1);
    ev_rd(32'h504, 32'h2, 1);
    drain();
    chk("resume_popped", pops - p0, 2);
    chk("resume_ts", last_ts, 2);

    // randomized traffic with rearming and a few trigger addresses
    do_reset();
    addrs[0] = 32'h600; addrs[1] = 32'h604; addrs[2] = 32'h608; addrs[3] = 32'h60C;
    trig_addr_i = addrs[$urandom_range(0, 3)];
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) post_count_i = 8'($urandom_range(0, 3));
      cyc(($urandom % 12) == 0, $urandom % 2, ($urandom % 4) == 0,
          addrs[$urandom_range(0, 3)],
          ($urandom % 2) ? 4'($urandom_range(1, 15)) : 4'd0,
          $urandom, $urandom, ($urandom % 3) != 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
